// File: rtl/rf_writeback_unit_pkg.sv
// Shared definitions for the register-file writeback unit:
// default widths, the hard-wired zero register index and a clog2 helper.
package rf_writeback_unit_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO       = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_writeback_unit_wb_fifo.sv
// Synchronous load-result buffer: address+data payload, strict FIFO order,
// occupancy count with full/empty flags derived from the registered count.
module wb_fifo
    import rf_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = clog2(DEPTH),
    localparam int CNT_W     = clog2(DEPTH) + 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iPush,
    input  logic [ADDR_WIDTH-1:0] iPushAddr,
    input  logic [DATA_WIDTH-1:0] iPushData,
    input  logic                  iPop,
    output logic [ADDR_WIDTH-1:0] oHeadAddr,
    output logic [DATA_WIDTH-1:0] oHeadData,
    output logic [CNT_W-1:0]      oCount,
    output logic                  oFull,
    output logic                  oEmpty
);

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]                 r_wr_ptr;
    logic [PTR_W-1:0]                 r_rd_ptr;
    logic [CNT_W-1:0]                 r_count;
    logic                             w_push;
    logic                             w_pop;

    assign oFull     = (r_count == CNT_W'(DEPTH));
    assign oEmpty    = (r_count == '0);
    assign oCount    = r_count;
    assign w_push    = iPush & ~oFull;
    assign w_pop     = iPop & ~oEmpty;
    assign oHeadAddr = r_mem[r_rd_ptr][ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign oHeadData = r_mem[r_rd_ptr][DATA_WIDTH-1:0];

    // Payload storage carries no reset; only pointers and count do.
    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {iPushAddr, iPushData};
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Merges ALU and buffered load results onto the single register-file write
// port and tracks in-flight destinations in a per-register scoreboard.
module rf_writeback_unit
    import rf_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iIssueValid,
    input  logic [ADDR_WIDTH-1:0] iIssueAddr,
    input  logic                  iAluValid,
    input  logic [ADDR_WIDTH-1:0] iAluAddr,
    input  logic [DATA_WIDTH-1:0] iAluData,
    input  logic                  iLdValid,
    input  logic [ADDR_WIDTH-1:0] iLdAddr,
    input  logic [DATA_WIDTH-1:0] iLdData,
    output logic                  oLdReady,
    output logic                  oWrEn,
    output logic [ADDR_WIDTH-1:0] oWrAddr,
    output logic [DATA_WIDTH-1:0] oWrData,
    input  logic [ADDR_WIDTH-1:0] iQueryAddr0,
    input  logic [ADDR_WIDTH-1:0] iQueryAddr1,
    output logic                  oBusy0,
    output logic                  oBusy1,
    output logic [CNT_W-1:0]      oFifoCount
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] w_fifo_addr;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_valid_p0;
    logic [ADDR_WIDTH-1:0] w_sel_addr_p0;
    logic [DATA_WIDTH-1:0] w_sel_data_p0;
    logic                  r_wr_en_p1;
    logic [ADDR_WIDTH-1:0] r_wr_addr_p1;
    logic [DATA_WIDTH-1:0] r_wr_data_p1;
    logic [NREG-1:0]       r_sb;
    logic [NREG-1:0]       w_sb_next;

    // Ready comes from the registered count only; a same-cycle pop earns no credit.
    assign oLdReady = iRst_n & ~w_fifo_full;
    assign w_push   = iLdValid & oLdReady;
    assign w_pop    = ~iAluValid & ~w_fifo_empty;

    wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iPush     (w_push),
        .iPushAddr (iLdAddr),
        .iPushData (iLdData),
        .iPop      (w_pop),
        .oHeadAddr (w_fifo_addr),
        .oHeadData (w_fifo_data),
        .oCount    (oFifoCount),
        .oFull     (w_fifo_full),
        .oEmpty    (w_fifo_empty)
    );

    // Stage p0: ALU has priority, otherwise drain the load buffer head.
    always_comb begin
        w_sel_valid_p0 = 1'b0;
        w_sel_addr_p0  = '0;
        w_sel_data_p0  = '0;
        if (iAluValid) begin
            w_sel_valid_p0 = 1'b1;
            w_sel_addr_p0  = iAluAddr;
            w_sel_data_p0  = iAluData;
        end else if (!w_fifo_empty) begin
            w_sel_valid_p0 = 1'b1;
            w_sel_addr_p0  = w_fifo_addr;
            w_sel_data_p0  = w_fifo_data;
        end
    end

    // Stage p1: registered write port; results to register zero are dropped here.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_wr_en_p1   <= 1'b0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
        end else begin
            r_wr_en_p1   <= w_sel_valid_p0 && (w_sel_addr_p0 != ADDR_WIDTH'(REG_ZERO));
            r_wr_addr_p1 <= w_sel_addr_p0;
            r_wr_data_p1 <= w_sel_data_p0;
        end
    end

    assign oWrEn   = r_wr_en_p1;
    assign oWrAddr = r_wr_addr_p1;
    assign oWrData = r_wr_data_p1;

    // Clear on the edge the file absorbs the write; a same-edge issue wins.
    always_comb begin
        w_sb_next = r_sb;
        if (r_wr_en_p1) begin
            w_sb_next[r_wr_addr_p1] = 1'b0;
        end
        if (iIssueValid) begin
            w_sb_next[iIssueAddr] = 1'b1;
        end
        w_sb_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    assign oBusy0 = r_sb[iQueryAddr0];
    assign oBusy1 = r_sb[iQueryAddr1];

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit: reset, ALU/load writeback, buffer
// backpressure, register zero, scoreboard set/clear and mid-run reset.
module tb_rf_writeback_unit;

    logic        iClk;
    logic        iRst_n;
    logic        iIssueValid;
    logic [4:0]  iIssueAddr;
    logic        iAluValid;
    logic [4:0]  iAluAddr;
    logic [31:0] iAluData;
    logic        iLdValid;
    logic [4:0]  iLdAddr;
    logic [31:0] iLdData;
    logic        oLdReady;
    logic        oWrEn;
    logic [4:0]  oWrAddr;
    logic [31:0] oWrData;
    logic [4:0]  iQueryAddr0;
    logic [4:0]  iQueryAddr1;
    logic        oBusy0;
    logic        oBusy1;
    logic [2:0]  oFifoCount;

    int checks;
    int failures;

    rf_writeback_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .FIFO_DEPTH (4)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iIssueValid (iIssueValid),
        .iIssueAddr  (iIssueAddr),
        .iAluValid   (iAluValid),
        .iAluAddr    (iAluAddr),
        .iAluData    (iAluData),
        .iLdValid    (iLdValid),
        .iLdAddr     (iLdAddr),
        .iLdData     (iLdData),
        .oLdReady    (oLdReady),
        .oWrEn       (oWrEn),
        .oWrAddr     (oWrAddr),
        .oWrData     (oWrData),
        .iQueryAddr0 (iQueryAddr0),
        .iQueryAddr1 (iQueryAddr1),
        .oBusy0      (oBusy0),
        .oBusy1      (oBusy1),
        .oFifoCount  (oFifoCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iIssueValid = 1'b0;
        iIssueAddr  = '0;
        iAluValid   = 1'b0;
        iAluAddr    = '0;
        iAluData    = '0;
        iLdValid    = 1'b0;
        iLdAddr     = '0;
        iLdData     = '0;
    endtask

    task automatic test_reset();
        iRst_n      = 1'b0;
        iAluValid   = 1'b1; iAluAddr = 5'd9; iAluData = 32'h5555_AAAA;
        iLdValid    = 1'b1; iLdAddr  = 5'd9; iLdData  = 32'h1111_2222;
        iIssueValid = 1'b1; iIssueAddr = 5'd9;
        iQueryAddr0 = 5'd9;
        cyc();
        cyc();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL reset_wren got=%0b exp=0", oWrEn); end
        checks++; if (oWrAddr !== 5'd0) begin failures++; $display("FAIL reset_wraddr got=%0d exp=0", oWrAddr); end
        checks++; if (oWrData !== 32'd0) begin failures++; $display("FAIL reset_wrdata got=%h exp=0", oWrData); end
        checks++; if (oFifoCount !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", oFifoCount); end
        checks++; if (oLdReady !== 1'b0) begin failures++; $display("FAIL reset_ldready got=%0b exp=0", oLdReady); end
        checks++; if (oBusy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", oBusy0); end
        idle_inputs();
        iRst_n = 1'b1;
        cyc();
        checks++; if (oLdReady !== 1'b1) begin failures++; $display("FAIL release_ldready got=%0b exp=1", oLdReady); end
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL release_wren got=%0b exp=0", oWrEn); end
    endtask

    task automatic test_alu_write();
        iAluValid = 1'b1; iAluAddr = 5'd5; iAluData = 32'hDEAD_BEEF;
        cyc();
        idle_inputs();
        checks++; if (oWrEn !== 1'b1) begin failures++; $display("FAIL alu_wren got=%0b exp=1", oWrEn); end
        checks++; if (oWrAddr !== 5'd5) begin failures++; $display("FAIL alu_wraddr got=%0d exp=5", oWrAddr); end
        checks++; if (oWrData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_wrdata got=%h exp=deadbeef", oWrData); end
        cyc();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL alu_after_wren got=%0b exp=0", oWrEn); end
        checks++; if (oFifoCount !== 3'd0) begin failures++; $display("FAIL alu_after_count got=%0d exp=0", oFifoCount); end
    endtask

    task automatic test_load_scoreboard();
        iQueryAddr0 = 5'd7;
        iIssueValid = 1'b1; iIssueAddr = 5'd7;
        cyc();
        idle_inputs();
        checks++; if (oBusy0 !== 1'b1) begin failures++; $display("FAIL issue_busy got=%0b exp=1", oBusy0); end
        iLdValid = 1'b1; iLdAddr = 5'd7; iLdData = 32'h0000_1234;
        #1;
        checks++; if (oLdReady !== 1'b1) begin failures++; $display("FAIL ld_ready got=%0b exp=1", oLdReady); end
        cyc();
        idle_inputs();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL ld_early_wren got=%0b exp=0", oWrEn); end
        checks++; if (oFifoCount !== 3'd1) begin failures++; $display("FAIL ld_count got=%0d exp=1", oFifoCount); end
        cyc();
        checks++; if (oWrEn !== 1'b1) begin failures++; $display("FAIL ld_wren got=%0b exp=1", oWrEn); end
        checks++; if (oWrAddr !== 5'd7) begin failures++; $display("FAIL ld_wraddr got=%0d exp=7", oWrAddr); end
        checks++; if (oWrData !== 32'h0000_1234) begin failures++; $display("FAIL ld_wrdata got=%h exp=00001234", oWrData); end
        checks++; if (oBusy0 !== 1'b1) begin failures++; $display("FAIL ld_busy_hold got=%0b exp=1", oBusy0); end
        cyc();
        checks++; if (oBusy0 !== 1'b0) begin failures++; $display("FAIL ld_busy_clear got=%0b exp=0", oBusy0); end
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL ld_after_wren got=%0b exp=0", oWrEn); end
    endtask

    task automatic test_back_to_back();
        int ld_idx;
        logic [2:0] exp_cnt [5];
        exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd2;
        exp_cnt[3] = 3'd1; exp_cnt[4] = 3'd0;
        ld_idx = 0;
        for (int i = 0; i < 6; i++) begin
            iAluValid = 1'b1;
            iAluAddr  = 5'(10 + i);
            iAluData  = 32'hA000_0000 + 32'(i);
            iLdValid  = (ld_idx < 5);
            iLdAddr   = 5'(20 + ld_idx);
            iLdData   = 32'h0000_0100 + 32'(ld_idx);
            #1;
            checks++; if (oLdReady !== (i < 4)) begin failures++; $display("FAIL bp_ready[%0d] got=%0b exp=%0b", i, oLdReady, (i < 4)); end
            if (oLdReady && iLdValid) ld_idx++;
            cyc();
            checks++; if (oWrEn !== 1'b1 || oWrAddr !== 5'(10 + i) || oWrData !== 32'hA000_0000 + 32'(i)) begin
                failures++; $display("FAIL bp_alu[%0d] got=%0b/%0d/%h exp=1/%0d/%h", i, oWrEn, oWrAddr, oWrData, 10 + i, 32'hA000_0000 + 32'(i));
            end
        end
        checks++; if (oFifoCount !== 3'd4) begin failures++; $display("FAIL bp_full_count got=%0d exp=4", oFifoCount); end
        iAluValid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            iLdValid = (ld_idx < 5);
            iLdAddr  = 5'(20 + ld_idx);
            iLdData  = 32'h0000_0100 + 32'(ld_idx);
            #1;
            checks++; if (oLdReady !== (j != 0)) begin failures++; $display("FAIL drain_ready[%0d] got=%0b exp=%0b", j, oLdReady, (j != 0)); end
            if (oLdReady && iLdValid) ld_idx++;
            cyc();
            checks++; if (oWrEn !== 1'b1 || oWrAddr !== 5'(20 + j) || oWrData !== 32'h0000_0100 + 32'(j)) begin
                failures++; $display("FAIL drain_wr[%0d] got=%0b/%0d/%h exp=1/%0d/%h", j, oWrEn, oWrAddr, oWrData, 20 + j, 32'h0000_0100 + 32'(j));
            end
            checks++; if (oFifoCount !== exp_cnt[j]) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", j, oFifoCount, exp_cnt[j]); end
        end
        idle_inputs();
        cyc();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL drain_done_wren got=%0b exp=0", oWrEn); end
    endtask

    task automatic test_reg_zero();
        iQueryAddr1 = 5'd0;
        iIssueValid = 1'b1; iIssueAddr = 5'd0;
        iAluValid   = 1'b1; iAluAddr   = 5'd0; iAluData = 32'hFFFF_0000;
        iLdValid    = 1'b1; iLdAddr    = 5'd0; iLdData  = 32'h0000_FFFF;
        cyc();
        idle_inputs();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL zero_alu_wren got=%0b exp=0", oWrEn); end
        checks++; if (oFifoCount !== 3'd1) begin failures++; $display("FAIL zero_count got=%0d exp=1", oFifoCount); end
        checks++; if (oBusy1 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b exp=0", oBusy1); end
        cyc();
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL zero_ld_wren got=%0b exp=0", oWrEn); end
        checks++; if (oFifoCount !== 3'd0) begin failures++; $display("FAIL zero_drained got=%0d exp=0", oFifoCount); end
        cyc();
        checks++; if (oBusy1 !== 1'b0) begin failures++; $display("FAIL zero_busy_late got=%0b exp=0", oBusy1); end
    endtask

    task automatic test_set_wins();
        iQueryAddr0 = 5'd3;
        iIssueValid = 1'b1; iIssueAddr = 5'd3;
        cyc();
        idle_inputs();
        iAluValid = 1'b1; iAluAddr = 5'd3; iAluData = 32'h0000_0033;
        cyc();
        idle_inputs();
        checks++; if (oWrEn !== 1'b1 || oWrAddr !== 5'd3) begin failures++; $display("FAIL sw_write got=%0b/%0d exp=1/3", oWrEn, oWrAddr); end
        iIssueValid = 1'b1; iIssueAddr = 5'd3;
        cyc();
        idle_inputs();
        checks++; if (oBusy0 !== 1'b1) begin failures++; $display("FAIL sw_set_wins got=%0b exp=1", oBusy0); end
        iAluValid = 1'b1; iAluAddr = 5'd3; iAluData = 32'h0000_0034;
        cyc();
        idle_inputs();
        cyc();
        checks++; if (oBusy0 !== 1'b0) begin failures++; $display("FAIL sw_clear got=%0b exp=0", oBusy0); end
    endtask

    task automatic test_reset_mid();
        iQueryAddr0 = 5'd1;
        iQueryAddr1 = 5'd2;
        for (int k = 0; k < 3; k++) begin
            iIssueValid = (k < 2);
            iIssueAddr  = 5'(k + 1);
            iAluValid   = 1'b1; iAluAddr = 5'd9; iAluData = 32'h0000_0900 + 32'(k);
            iLdValid    = 1'b1; iLdAddr  = 5'(k + 1); iLdData = 32'h0000_0500 + 32'(k);
            cyc();
        end
        checks++; if (oFifoCount !== 3'd3) begin failures++; $display("FAIL mid_count got=%0d exp=3", oFifoCount); end
        checks++; if (oBusy0 !== 1'b1 || oBusy1 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b%0b exp=11", oBusy0, oBusy1); end
        iRst_n = 1'b0;
        iIssueValid = 1'b1; iIssueAddr = 5'd1;
        #1;
        checks++; if (oLdReady !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%0b exp=0", oLdReady); end
        cyc();
        checks++; if (oFifoCount !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", oFifoCount); end
        checks++; if (oBusy0 !== 1'b0 || oBusy1 !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b%0b exp=00", oBusy0, oBusy1); end
        checks++; if (oWrEn !== 1'b0) begin failures++; $display("FAIL mid_rst_wren got=%0b exp=0", oWrEn); end
        idle_inputs();
        iRst_n = 1'b1;
        cyc();
        checks++; if (oWrEn !== 1'b0 || oLdReady !== 1'b1) begin failures++; $display("FAIL mid_post got=%0b/%0b exp=0/1", oWrEn, oLdReady); end
        cyc();
        checks++; if (oWrEn !== 1'b0 || oFifoCount !== 3'd0) begin failures++; $display("FAIL mid_post2 got=%0b/%0d exp=0/0", oWrEn, oFifoCount); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        iRst_n   = 1'b0;
        iQueryAddr0 = '0;
        iQueryAddr1 = '0;
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load_scoreboard();
        test_back_to_back();
        test_reg_zero();
        test_set_wins();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_writeback_unit.md
# rf_writeback_unit

Writeback-side counterpart of the triple-ported register file: merges results from the single-cycle ALU path and the variable-latency load path into the file's single write port, one write per cycle. Holds a register scoreboard so the decode/issue stage can test whether a source or destination register still has a write in flight. Sits between the execute/memory stages and the register file write port (iEnWrite/iAddrWrite/iDataWrite).

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers; index 0 hard-wired zero)
- FIFO_DEPTH, 4, load-result buffer entries (power of two, ≥2)

- iClk  in  1  clock
- iRst_n  in  1  reset, synchronous, active-low
- iIssueValid  in  1  instruction with a destination register issued this cycle
- iIssueAddr  in  ADDR_WIDTH  destination register of issued instruction
- iAluValid  in  1  ALU result valid (no backpressure)
- iAluAddr  in  ADDR_WIDTH  ALU destination
- iAluData  in  DATA_WIDTH  ALU result
- iLdValid  in  1  load result offered
- iLdAddr  in  ADDR_WIDTH  load destination
- iLdData  in  DATA_WIDTH  load data
- oLdReady  out  1  load result accepted when iLdValid & oLdReady
- oWrEn  out  1  register file write enable
- oWrAddr  out  ADDR_WIDTH  register file write address
- oWrData  out  DATA_WIDTH  register file write data
- iQueryAddr0, iQueryAddr1  in  ADDR_WIDTH  scoreboard lookup addresses
- oBusy0, oBusy1  out  1  queried register has a pending write
- oFifoCount  out  clog2(FIFO_DEPTH)+1  load-buffer occupancy

## Operation
- Write selection per cycle: ALU valid → ALU result; else FIFO non-empty → FIFO head (dequeued); else no write.
- ALU path never stalls; loads wait in FIFO while ALU occupies the port.
- Loads always pass through the FIFO (no bypass), strict FIFO order.
- oLdReady = (count < FIFO_DEPTH), from registered count only; no credit for a same-cycle dequeue.
- Simultaneous enqueue and dequeue: count unchanged; FIFO full with dequeue still deasserts oLdReady that cycle.
- Register 0: results addressed to 0 are consumed (FIFO entry dequeued, ALU accepted) but oWrEn stays 0; issue to 0 never sets scoreboard; oBusy for address 0 always 0.
- Scoreboard: one bit per register. Set on iIssueValid; cleared in the cycle a write to that address is selected (when oWrEn is registered high). Same-cycle set and clear of the same address: set wins.
- oBusyN combinational from scoreboard register (not forwarded from this cycle's set/clear).
- Ordering between ALU and load results to the same register is not enforced here; issue stage must stall while destination oBusy is set.
- Result to a register whose scoreboard bit is clear: still written, scoreboard unchanged.

## Timing
- Reset: oWrEn=0, oWrAddr=0, oWrData=0, FIFO empty, oFifoCount=0, scoreboard all clear, oBusy0/1=0. oLdReady=0 while iRst_n low, 1 from first cycle after release; inputs during reset ignored.
- Reset mid-operation: FIFO contents and pending scoreboard bits discarded; no write issued in the cycle after reset edge.
- ALU latency: iAluValid at edge N → oWrEn/oWrAddr/oWrData valid for cycle N+1 (registered outputs).
- Load latency, FIFO empty, no ALU: accepted at edge N → oWrEn in cycle N+2.
- Each ALU-valid cycle delays FIFO drain by one cycle.
- oBusy drops the cycle after the write is presented on oWrEn+1 edge, i.e. coincident with the register file holding new data.
- Throughput: one write per cycle sustained.

## Structure
- Shared package: DATA_WIDTH, ADDR_WIDTH defaults, zero-register index constant, clog2 helper.
- Sub-module wb_fifo: synchronous FIFO (data+addr payload, count, full/empty), same clock/reset.
- Top: select mux, output registers, scoreboard vector, query muxes.

## Test plan
- Reset then ALU write addr 5, data 0xDEADBEEF → oWrEn=1, oWrAddr=5, oWrData=0xDEADBEEF one cycle later; nothing else.
- Issue addr 7, query 7 → oBusy0=1 next cycle; load 7/0x1234 accepted with no ALU → write at +2, oBusy0=0 the cycle after.
- ALU valid 6 consecutive cycles while 5 loads offered → oLdReady drops after 4 accepted, oFifoCount=4; after ALU stops, 4 loads written in order, then 5th accepted.
- ALU and load both to addr 0 → no oWrEn, FIFO drains, oBusy for 0 stays 0.
- Issue to addr 3 same cycle write to 3 selected → scoreboard bit 3 remains set.
- FIFO holding 3 entries, scoreboard bits 1,2 set, assert iRst_n=0 one cycle → oFifoCount=0, oBusy all 0, oLdReady=0 during reset, no write afterward.
